rcv_fifo_ctrl: RTL

Control block for the receive FIFO storage. It arbitrates two enqueue requesters (A: receive path, B: loopback/test path) with round-robin priority and owns the head/tail pointers, each with its own wrap toggle bit. It drives write enable, write select and read/write addresses to the FIFO register file, and produces full, empty and count status for the downstream consumer. A synchronous flush sequence empties the FIFO without asserting reset.

---
 rtl/rcv_fifo_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rcv_fifo_ctrl.sv
// Receive FIFO control: round-robin enqueue arbitration (A/B), head/tail pointers
// with wrap toggles, status flags and a one-cycle flush. Optional RCV_FIFO_ERR_FLAGS_EN.
module rcv_fifo_ctrl #(
   parameter  int DEPTH = 3,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             enq_req_a,
   input  logic             enq_req_b,
   input  logic             rcv_deq,
   input  logic             flush,
`ifdef RCV_FIFO_ERR_FLAGS_EN
   input  logic             err_clr,
   output logic             ovf_err,
   output logic             udf_err,
`endif
   output logic             grant_a,
   output logic             grant_b,
   output logic             wr_en,
   output logic             wr_sel,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count,
   output logic             busy
);

   typedef enum logic {RUN, FLUSH} state_e;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(DEPTH);

   state_e           state_q, state_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic             head_tog_q, head_tog_d, tail_tog_q, tail_tog_d;
   logic             last_grant_q, last_grant_d;   // 0 = A, 1 = B
   logic             busy_q, busy_d;
   logic             run, ptr_eq, can_enq, deq_ok;

   assign run    = (state_q == RUN) & n_rst;
   assign ptr_eq = (head_q == tail_q);
   assign empty  = ptr_eq & (head_tog_q == tail_tog_q);
   assign full   = ptr_eq & (head_tog_q != tail_tog_q);
   assign count  = (head_tog_q == tail_tog_q) ? ({1'b0, tail_q} - {1'b0, head_q})
                                              : (DEPTH_C - {1'b0, head_q} + {1'b0, tail_q});

   // On contention the requester that did not win last time is granted.
   assign can_enq = run & ~full;
   assign grant_a = can_enq & enq_req_a & (~enq_req_b | last_grant_q);
   assign grant_b = can_enq & enq_req_b & (~enq_req_a | ~last_grant_q);
   assign wr_en   = grant_a | grant_b;
   assign wr_sel  = grant_b;
   assign wr_ptr  = tail_q;
   assign rd_ptr  = head_q;
   assign busy    = busy_q;
   assign deq_ok  = run & rcv_deq & ~empty;

   always_comb begin
      state_d      = state_q;
      head_d       = head_q;
      tail_d       = tail_q;
      head_tog_d   = head_tog_q;
      tail_tog_d   = tail_tog_q;
      last_grant_d = last_grant_q;
      if (wr_en) begin
         last_grant_d = grant_b;
         if (tail_q == PTR_LAST) begin
            tail_d     = '0;
            tail_tog_d = ~tail_tog_q;
         end else begin
            tail_d = tail_q + PTR_W'(1);
         end
      end
      if (deq_ok) begin
         if (head_q == PTR_LAST) begin
            head_d     = '0;
            head_tog_d = ~head_tog_q;
         end else begin
            head_d = head_q + PTR_W'(1);
         end
      end
      case (state_q)
         RUN:   if (flush) state_d = FLUSH;
         FLUSH: begin
            state_d    = RUN;
            head_d     = '0;
            tail_d     = '0;
            head_tog_d = 1'b0;
            tail_tog_d = 1'b0;
         end
         default: state_d = RUN;
      endcase
      busy_d = (state_d == FLUSH);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= RUN;
         head_q       <= '0;
         tail_q       <= '0;
         head_tog_q   <= 1'b0;
         tail_tog_q   <= 1'b0;
         last_grant_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         head_tog_q   <= head_tog_d;
         tail_tog_q   <= tail_tog_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
      end
   end

`ifdef RCV_FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d, udf_q, udf_d;

   always_comb begin
      ovf_d = ovf_q | (run & (enq_req_a | enq_req_b) & full);
      udf_d = udf_q | (run & rcv_deq & empty);
      if (err_clr | flush) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign ovf_err = ovf_q;
   assign udf_err = udf_q;
`endif

endmodule
